ser_loader: RTL and testbench

SER_LOADER -- requirements
Module: ser_loader

---
 rtl/ser_loader.sv | 126 ++++++++++++
 tb/tb_ser_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ser_loader.sv
// Serial-to-parallel word loader: framed bit stream plus even parity, loaded into datao on good parity.
// Latency: 1 cycle; datao/we (or perr) update on the edge that samples the parity bit.
// Backpressure: none; one bit is consumed on every sdv cycle, and the block never stalls the source.
module ser_loader #(
    parameter int width     = 8,
    parameter bit msb_first = 1'b1
) (
    input  logic             clk,
    input  logic             resetna,
    input  logic             resetns,
    input  logic             sdi,
    input  logic             sdv,
    input  logic             sfr,
    output logic [width-1:0] datao,
    output logic             we,
    output logic             perr,
    output logic             ferr,
    output logic             busy
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // A one-bit word has no data bits left to shift after the first one.
    localparam state_t RESTART = (width == 1) ? PARITY : SHIFT;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] sr_q, sr_d;
    logic [width-1:0] first_w;
    logic [width-1:0] shift_w;
    logic             load;
    logic             perr_d;
    logic             ferr_d;

    // The first bit is placed so that width-1 further shifts move it to its final position.
    assign first_w = msb_first ? width'(sdi) : (width'(sdi) << (width - 1));
    assign shift_w = msb_first ? ((sr_q << 1) | width'(sdi))
                               : ((sr_q >> 1) | (width'(sdi) << (width - 1)));

    assign busy = (state_q != IDLE);

    // Next state, shift register, counter and pulse requests; sdv=0 holds everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        load    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (sdv) begin
            if (sfr) begin
                // Frame start always wins, including over a bit expected as parity.
                ferr_d  = (state_q != IDLE);
                state_d = RESTART;
                cnt_d   = CW'(1);
                sr_d    = first_w;
            end else begin
                case (state_q)
                    SHIFT: begin
                        sr_d  = shift_w;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(width)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        if (^{sr_q, sdi} == 1'b0) begin
                            load = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State register with asynchronous and synchronous clear.
    always_ff @(posedge clk or negedge resetna) begin
        if (!resetna) begin
            state_q <= IDLE;
        end else if (!resetns) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output pulses; datao only ever takes a complete, parity-checked word.
    always_ff @(posedge clk or negedge resetna) begin
        if (!resetna) begin
            cnt_q <= '0;
            sr_q  <= '0;
            datao <= '0;
            we    <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else if (!resetns) begin
            cnt_q <= '0;
            sr_q  <= '0;
            datao <= '0;
            we    <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            if (load) begin
                datao <= sr_q;
            end
            we   <= load;
            perr <= perr_d;
            ferr <= ferr_d;
        end
    end

endmodule

// File: tb/tb_ser_loader.sv
// Bench for ser_loader: two instances (msb-first and lsb-first) share one stimulus stream.
// A frame-level model predicts datao/we/perr/ferr/busy and is compared every cycle.
// Directed scenarios are followed by a randomized stream including aborts and resets.
module tb_ser_loader;

    logic       clk = 1'b0;
    logic       resetna, resetns, sdi, sdv, sfr;
    logic [7:0] datao_m, datao_l;
    logic       we_m, perr_m, ferr_m, busy_m;
    logic       we_l, perr_l, ferr_l, busy_l;

    always #5 clk = ~clk;

    ser_loader #(.width(8), .msb_first(1'b1)) dut_m (
        .clk(clk), .resetna(resetna), .resetns(resetns), .sdi(sdi), .sdv(sdv), .sfr(sfr),
        .datao(datao_m), .we(we_m), .perr(perr_m), .ferr(ferr_m), .busy(busy_m)
    );

    ser_loader #(.width(8), .msb_first(1'b0)) dut_l (
        .clk(clk), .resetna(resetna), .resetns(resetns), .sdi(sdi), .sdv(sdv), .sfr(sfr),
        .datao(datao_l), .we(we_l), .perr(perr_l), .ferr(ferr_l), .busy(busy_l)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level model: bits of the current frame in arrival order.
    bit         m_inf = 1'b0;
    int         m_cnt = 0;
    bit   [7:0] m_b   = '0;
    logic [7:0] m_dm  = '0;
    logic [7:0] m_dl  = '0;
    bit         m_we = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

    task automatic model_reset();
        m_inf = 1'b0; m_cnt = 0; m_b = '0;
        m_dm = '0; m_dl = '0;
        m_we = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] w;
        m_we = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        if (!resetna || !resetns) begin
            model_reset();
        end else if (sdv) begin
            if (sfr) begin
                if (m_inf) m_ferr = 1'b1;
                m_inf = 1'b1;
                m_b   = '0;
                m_b[0] = sdi;
                m_cnt = 1;
            end else if (m_inf) begin
                if (m_cnt < 8) begin
                    m_b[m_cnt] = sdi;
                    m_cnt++;
                end else begin
                    if ((^m_b ^ sdi) == 1'b0) begin
                        m_we = 1'b1;
                        w = '0;
                        for (int i = 0; i < 8; i++) w[7-i] = m_b[i];
                        m_dm = w;
                        m_dl = m_b;
                    end else begin
                        m_perr = 1'b1;
                    end
                    m_inf = 1'b0;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("datao_msb", datao_m, m_dm);
        chk("datao_lsb", datao_l, m_dl);
        chk("we_msb",    we_m,    m_we);
        chk("we_lsb",    we_l,    m_we);
        chk("perr_msb",  perr_m,  m_perr);
        chk("perr_lsb",  perr_l,  m_perr);
        chk("ferr_msb",  ferr_m,  m_ferr);
        chk("ferr_lsb",  ferr_l,  m_ferr);
        chk("busy_msb",  busy_m,  m_inf);
        chk("busy_lsb",  busy_l,  m_inf);
    endtask

    // Model advances on the rising edge; outputs are compared on the falling edge.
    always @(clk) begin
        if (clk) begin
            model_step();
        end else begin
            if (!resetna) model_reset();
            compare();
        end
    end

    // Drive one cycle of inputs, then return 2 time units after the edge that sampled them.
    task automatic cyc(input logic v, input logic f, input logic d);
        sdv = v; sfr = f; sdi = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic tail(input logic [7:0] d, input int start, input logic p, input int gap);
        for (int i = start; i >= 0; i--) begin
            idle(gap);
            cyc(1'b1, 1'b0, d[i]);
        end
        idle(gap);
        cyc(1'b1, 1'b0, p);
    endtask

    // Sends d[7] first, so the msb-first instance sees d and the lsb-first one its bit reverse.
    task automatic frame(input logic [7:0] d, input logic p, input int gap);
        cyc(1'b1, 1'b1, d[7]);
        tail(d, 6, p, gap);
    endtask

    initial begin
        logic [7:0] rd;
        resetna = 1'b0; resetns = 1'b1; sdv = 1'b0; sfr = 1'b0; sdi = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy",  busy_m,  1'b0);
        chk("rst_datao", datao_m, 8'h00);
        chk("rst_we",    we_m,    1'b0);
        resetna = 1'b1;
        idle(2);

        // Good A5 frame, continuous sdv.
        frame(8'hA5, 1'b0, 0);
        chk("a5_we",      we_m,    1'b1);
        chk("a5_datao_m", datao_m, 8'hA5);
        chk("a5_datao_l", datao_l, 8'hA5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a5_we_off",  we_m,    1'b0);
        chk("a5_busy",    busy_m,  1'b0);

        // Same frame, bad parity.
        frame(8'hA5, 1'b1, 0);
        chk("bad_perr",  perr_m,  1'b1);
        chk("bad_we",    we_m,    1'b0);
        chk("bad_datao", datao_m, 8'hA5);

        // 3C with sdv every other cycle.
        frame(8'h3C, 1'b0, 1);
        chk("gap_we",    we_m,    1'b1);
        chk("gap_datao", datao_m, 8'h3C);
        idle(1);
        frame(8'hA5, 1'b0, 0);

        // Abort after three bits, restart with 3C.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("abort_ferr", ferr_m, 1'b1);
        chk("abort_busy", busy_m, 1'b1);
        tail(8'h3C, 6, 1'b0, 0);
        chk("abort_we",    we_m,    1'b1);
        chk("abort_perr",  perr_m,  1'b0);
        chk("abort_datao", datao_m, 8'h3C);

        // Synchronous reset after five bits, with a competing frame start.
        cyc(1'b1, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        resetns = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        resetns = 1'b1;
        chk("srst_busy",  busy_m,  1'b0);
        chk("srst_datao", datao_m, 8'h00);
        chk("srst_ferr",  ferr_m,  1'b0);
        frame(8'h81, 1'b0, 0);
        chk("srst_81", datao_m, 8'h81);

        // Asynchronous reset after five bits: outputs clear before any edge.
        cyc(1'b1, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        sdv = 1'b0;
        resetna = 1'b0;
        #1;
        chk("arst_busy",  busy_m,  1'b0);
        chk("arst_datao", datao_m, 8'h00);
        chk("arst_we",    we_m,    1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        resetna = 1'b1;
        frame(8'h81, 1'b0, 0);
        chk("arst_81", datao_m, 8'h81);

        // lsb-first: bits 1,0,0,0,0,0,0,0 then a back-to-back second frame.
        frame(8'h80, 1'b1, 0);
        chk("lsb_01",    datao_l, 8'h01);
        chk("lsb_we1",   we_l,    1'b1);
        chk("msb_80",    datao_m, 8'h80);
        frame(8'h40, 1'b1, 0);
        chk("lsb_02",    datao_l, 8'h02);
        chk("lsb_we2",   we_l,    1'b1);

        // Randomized stream: whole frames mixed with arbitrary bits, aborts and sync resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd = 8'($urandom);
                frame(rd, (^rd) ^ ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
            end else begin
                resetns = ($urandom_range(0, 63) != 0);
                cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 7) == 0), 1'($urandom));
                resetns = 1'b1;
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
